// File: rtl/joy_pkg.sv
// -----------------------------------------------------------------------------
// joy_pkg
// Shared constants and types for the joystick setpoint mapper. The feedback
// controller also uses these constants.
//   FRAC_W      : fractional bits of the Q3.10 plate-angle setpoint
//   SPAN_15DEG  : full-scale setpoint code for the 15 degree plate range
//   SPAN_30DEG  : full-scale setpoint code for the 30 degree plate range
//   joy_state_t : mapper FSM state encoding (IDLE/CALC/DONE)
// -----------------------------------------------------------------------------
package joy_pkg;

  localparam int FRAC_W     = 10;
  localparam int SPAN_15DEG = 85;
  localparam int SPAN_30DEG = 170;

  typedef logic [1:0] joy_state_t;

  localparam joy_state_t IDLE = 2'd0;
  localparam joy_state_t CALC = 2'd1;
  localparam joy_state_t DONE = 2'd2;

endpackage

// File: rtl/joy_setpoint_mapper_if.sv
// -----------------------------------------------------------------------------
// joy_setpoint_mapper_if
// Sample-in / setpoint-out bundle of the joystick setpoint mapper.
//   in_valid  : source has a new packed sample set on joy_in
//   in_ready  : mapper is idle and will take the sample set
//   joy_in    : N_CH unsigned ADC samples, channel 0 in the LSBs
//   setpoint  : N_CH signed setpoints, channel 0 in the LSBs
//   out_valid : one-cycle pulse when setpoint has been updated
// Modports: master = sample source / setpoint consumer, slave = mapper.
// -----------------------------------------------------------------------------
interface joy_setpoint_mapper_if #(
  parameter int N_CH  = 2,
  parameter int ADC_W = 12,
  parameter int OUT_W = 13
);

  logic                    in_valid;
  logic                    in_ready;
  logic [N_CH*ADC_W-1:0]   joy_in;
  logic [N_CH*OUT_W-1:0]   setpoint;
  logic                    out_valid;

  modport master (
    output in_valid,
    output joy_in,
    input  in_ready,
    input  setpoint,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  joy_in,
    output in_ready,
    output setpoint,
    output out_valid
  );

endinterface

// File: rtl/joy_slew_limiter.sv
// -----------------------------------------------------------------------------
// joy_slew_limiter
// Combinational next-setpoint function for one channel.
// Optional feature macro: JOY_SLEW_EN
//   defined   : move from cur toward target by at most SLEW_STEP
//   undefined : nxt = target (cur and SLEW_STEP ignored)
// Ports:
//   cur    : current signed setpoint of the channel
//   target : new clamped target of the channel
//   nxt    : value to store as the channel's next setpoint
// -----------------------------------------------------------------------------
module joy_slew_limiter #(
  parameter int OUT_W     = 13,
  parameter int SLEW_STEP = 8
) (
  input  logic signed [OUT_W-1:0] cur,
  input  logic signed [OUT_W-1:0] target,
  output logic signed [OUT_W-1:0] nxt
);

`ifdef JOY_SLEW_EN
  localparam logic signed [OUT_W:0]   STEP_W = (OUT_W+1)'(SLEW_STEP);
  localparam logic signed [OUT_W-1:0] STEP_N = OUT_W'(SLEW_STEP);

  // One extra bit so target - cur cannot wrap at the range ends
  logic signed [OUT_W:0] diff;

  always_comb begin
    diff = {target[OUT_W-1], target} - {cur[OUT_W-1], cur};
    if (diff > STEP_W) begin
      nxt = cur + STEP_N;
    end else if (diff < -STEP_W) begin
      nxt = cur - STEP_N;
    end else begin
      nxt = target;
    end
  end
`else
  localparam int unused_step = SLEW_STEP;
  logic          unused_cur;

  assign unused_cur = ^cur;
  assign nxt        = target;
`endif

endmodule

// File: rtl/joy_setpoint_mapper.sv
// -----------------------------------------------------------------------------
// joy_setpoint_mapper
// Maps N_CH unsigned joystick ADC samples to signed Q3.10 plate-angle
// setpoints in +/-SPAN, with a centre deadband and an optional slew limiter.
// One multiplier is shared by all channels: one channel per cycle in CALC.
// Optional feature macro: JOY_SLEW_EN (see joy_slew_limiter).
// Ports:
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : joy_setpoint_mapper_if.slave
//             (in_valid/in_ready/joy_in in, setpoint/out_valid out)
// Timing: accept on edge E0, CALC in cycles 1..N_CH, setpoint updates on the
// edge ending cycle N_CH, out_valid in cycle N_CH+1, in_ready in N_CH+2.
// -----------------------------------------------------------------------------
module joy_setpoint_mapper
  import joy_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int ADC_W     = 12,
  parameter int OUT_W     = 3 + FRAC_W,
  parameter int SPAN      = SPAN_15DEG,
  parameter int DEADBAND  = 16,
  parameter int SLEW_STEP = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  joy_setpoint_mapper_if.slave bus
);

  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CEN_W  = ADC_W + 1;
  localparam int SPAN_W = $clog2(2 * SPAN + 1) + 1;
  localparam int PROD_W = CEN_W + SPAN_W;

  localparam logic signed [CEN_W-1:0]  CENTRE  = CEN_W'(2 ** (ADC_W - 1));
  localparam logic signed [CEN_W-1:0]  DB_MAG  = CEN_W'(DEADBAND);
  localparam logic signed [PROD_W-1:0] SPAN2_X = PROD_W'(2 * SPAN);
  localparam logic signed [PROD_W-1:0] SPAN_HI = PROD_W'(SPAN);
  localparam logic signed [PROD_W-1:0] SPAN_LO = -SPAN_HI;
  localparam logic signed [OUT_W-1:0]  SPAN_O  = OUT_W'(SPAN);

  // Arithmetic shift right by ADC_W: floor division by 2^ADC_W
  function automatic logic signed [PROD_W-1:0] scale_floor(
    input logic signed [PROD_W-1:0] p
  );
    return p >>> ADC_W;
  endfunction

  // Clamp a full-width scaled value to [-SPAN, +SPAN] at OUT_W bits
  function automatic logic signed [OUT_W-1:0] sat_span(
    input logic signed [PROD_W-1:0] v
  );
    if (v > SPAN_HI) begin
      return SPAN_O;
    end else if (v < SPAN_LO) begin
      return -SPAN_O;
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

  joy_state_t            state_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [N_CH*ADC_W-1:0] samp_p0;
  logic [N_CH*OUT_W-1:0] stage_p1;
  logic [N_CH*OUT_W-1:0] setpoint_p2;
  logic [N_CH*OUT_W-1:0] stage_next;

  logic                     accept;
  logic                     last_ch;
  logic [ADC_W-1:0]         x_sel;
  logic signed [CEN_W-1:0]  cen;
  logic signed [CEN_W-1:0]  mag;
  logic signed [PROD_W-1:0] cen_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  target;
  logic signed [OUT_W-1:0]  cur_sp;
  logic signed [OUT_W-1:0]  lim_nxt;

  // Handshake outputs are held off while reset is asserted
  assign bus.in_ready  = reset_n && (state_p0 == IDLE);
  assign bus.out_valid = reset_n && (state_p0 == DONE);
  assign bus.setpoint  = setpoint_p2;

  assign accept  = bus.in_ready && bus.in_valid;
  assign last_ch = (idx_p0 == IDX_W'(N_CH - 1));

  // ---- stage p0 -> p1: muxed channel through the shared multiplier ----
  assign x_sel  = samp_p0[int'(idx_p0) * ADC_W +: ADC_W];
  assign cur_sp = $signed(setpoint_p2[int'(idx_p0) * OUT_W +: OUT_W]);

  always_comb begin
    cen    = $signed({1'b0, x_sel}) - CENTRE;
    mag    = cen[CEN_W-1] ? -cen : cen;
    cen_x  = PROD_W'(cen);
    prod   = cen_x * SPAN2_X;
    target = (mag <= DB_MAG) ? '0 : sat_span(scale_floor(prod));
  end

  joy_slew_limiter #(
    .OUT_W     (OUT_W),
    .SLEW_STEP (SLEW_STEP)
  ) u_slew (
    .cur    (cur_sp),
    .target (target),
    .nxt    (lim_nxt)
  );

  always_comb begin
    stage_next = stage_p1;
    stage_next[int'(idx_p0) * OUT_W +: OUT_W] = lim_nxt;
  end

  // ---- control: FSM, channel index, published setpoint ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_p0    <= IDLE;
      idx_p0      <= '0;
      setpoint_p2 <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (bus.in_valid) begin
            state_p0 <= CALC;
            idx_p0   <= '0;
          end
        end
        CALC: begin
          if (last_ch) begin
            state_p0    <= DONE;
            setpoint_p2 <= stage_next;
          end else begin
            idx_p0 <= idx_p0 + 1'b1;
          end
        end
        DONE:    state_p0 <= IDLE;
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // ---- data: sample latch and per-channel staging ----
  always_ff @(posedge clock) begin
    if (accept) begin
      samp_p0 <= bus.joy_in;
    end
    if (state_p0 == CALC) begin
      stage_p1 <= stage_next;
    end
  end

endmodule

// File: tb/tb_joy_setpoint_mapper.sv
// -----------------------------------------------------------------------------
// tb_joy_setpoint_mapper
// Directed bench for joy_setpoint_mapper at default parameters
// (N_CH=2, ADC_W=12, OUT_W=13, SPAN=85, DEADBAND=16, SLEW_STEP=8).
// With JOY_SLEW_EN defined the slew sequence runs instead of the
// single-step mapping vectors.
// -----------------------------------------------------------------------------
module tb_joy_setpoint_mapper;

  logic clock = 1'b0;
  logic reset_n;

  int vectors    = 0;
  int miscompares = 0;

  joy_setpoint_mapper_if #(.N_CH(2), .ADC_W(12), .OUT_W(13)) bus ();

  joy_setpoint_mapper #(
    .N_CH      (2),
    .ADC_W     (12),
    .OUT_W     (13),
    .SPAN      (85),
    .DEADBAND  (16),
    .SLEW_STEP (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ch(input int i);
    logic [25:0] sp;
    sp = bus.setpoint;
    return sp[i*13 +: 13];
  endfunction

  // Present one sample set in IDLE and follow it to the end of DONE.
  task automatic run_set(input string tag, input logic [11:0] x0, input logic [11:0] x1,
                         input logic [12:0] e0, input logic [12:0] e1);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.joy_in   = {x1, x0};
    bus.in_valid = 1'b1;
    tick();                                  // E0 -> cycle 1
    bus.in_valid = 1'b0;
    bus.joy_in   = '0;
    check({tag, "_c1_ov"}, 32'(bus.out_valid), 32'd0);
    tick();                                  // cycle 2
    check({tag, "_c2_ov"}, 32'(bus.out_valid), 32'd0);
    tick();                                  // cycle 3
    check({tag, "_c3_ov"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_ch0"}, 32'(ch(0)), 32'(e0));
    check({tag, "_ch1"}, 32'(ch(1)), 32'(e1));
    tick();                                  // cycle 4
    check({tag, "_c4_ov"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.joy_in   = '0;

    // Reset held for three cycles
    repeat (3) tick();
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_ov", 32'(bus.out_valid), 32'd0);
    check("rst_sp", 32'(bus.setpoint), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_ov", 32'(bus.out_valid), 32'd0);
    check("post_rst_sp", 32'(bus.setpoint), 32'd0);

`ifdef JOY_SLEW_EN
    // x stepped to full scale: 8,16,...,80 then 84 on the 11th update
    run_set("slew_up1", 12'd4095, 12'd2048, 13'd8, 13'd0);
    run_set("slew_up2", 12'd4095, 12'd2048, 13'd16, 13'd0);
    run_set("slew_up3", 12'd4095, 12'd2048, 13'd24, 13'd0);
    run_set("slew_up4", 12'd4095, 12'd2048, 13'd32, 13'd0);
    run_set("slew_up5", 12'd4095, 12'd2048, 13'd40, 13'd0);
    run_set("slew_up6", 12'd4095, 12'd2048, 13'd48, 13'd0);
    run_set("slew_up7", 12'd4095, 12'd2048, 13'd56, 13'd0);
    run_set("slew_up8", 12'd4095, 12'd2048, 13'd64, 13'd0);
    run_set("slew_up9", 12'd4095, 12'd2048, 13'd72, 13'd0);
    run_set("slew_up10", 12'd4095, 12'd2048, 13'd80, 13'd0);
    run_set("slew_up11", 12'd4095, 12'd2048, 13'd84, 13'd0);
    // Step back to centre: descend by 8 per update
    run_set("slew_dn1", 12'd2048, 12'd2048, 13'd76, 13'd0);
    run_set("slew_dn2", 12'd2048, 12'd2048, 13'd68, 13'd0);
    run_set("slew_dn3", 12'd2048, 12'd2048, 13'd60, 13'd0);
`else
    // Full-scale corners: +84 and -85
    run_set("corner", 12'd4095, 12'd0, 13'h0054, 13'h1FAB);
    // Deadband edge: centre and centre+16 both map to 0
    run_set("deadband", 12'd2048, 12'd2064, 13'h0000, 13'h0000);
    // Just outside deadband: floor gives +0 and -1
    run_set("floor17", 12'd2065, 12'd2031, 13'h0000, 13'h1FFF);
    // Half scale: 42.5 -> 42, -42.5 -> -43
    run_set("half", 12'd3072, 12'd1024, 13'h002A, 13'h1FD5);

    // in_valid held high: sets A, B, C each accepted once, 4 cycles apart
    bus.joy_in   = {12'd1024, 12'd3072};     // A
    bus.in_valid = 1'b1;
    tick();                                  // A accepted, cycle 1
    bus.joy_in = {12'd4095, 12'd2048};       // B, held while busy
    check("hold_c1_ready", 32'(bus.in_ready), 32'd0);
    tick();
    tick();                                  // cycle 3 of A
    check("hold_a_ov", 32'(bus.out_valid), 32'd1);
    check("hold_a_ch0", 32'(ch(0)), 32'h002A);
    check("hold_a_ch1", 32'(ch(1)), 32'h1FD5);
    tick();                                  // cycle 4: idle again
    check("hold_a_ready", 32'(bus.in_ready), 32'd1);
    tick();                                  // B accepted on previous edge
    bus.joy_in = {12'd2031, 12'd2065};       // C
    check("hold_b_c1_ready", 32'(bus.in_ready), 32'd0);
    tick();
    tick();                                  // cycle 3 of B
    check("hold_b_ov", 32'(bus.out_valid), 32'd1);
    check("hold_b_ch0", 32'(ch(0)), 32'h0000);
    check("hold_b_ch1", 32'(ch(1)), 32'h0054);
    tick();
    check("hold_b_ready", 32'(bus.in_ready), 32'd1);
    tick();                                  // C accepted
    tick();
    tick();                                  // cycle 3 of C
    check("hold_c_ov", 32'(bus.out_valid), 32'd1);
    check("hold_c_ch0", 32'(ch(0)), 32'h0000);
    check("hold_c_ch1", 32'(ch(1)), 32'h1FFF);
    tick();                                  // cycle 4 of C
    bus.in_valid = 1'b0;
    check("hold_c_ready", 32'(bus.in_ready), 32'd1);
    tick();                                  // nothing accepted: still idle
    check("hold_end_ready", 32'(bus.in_ready), 32'd1);
    check("hold_end_ov", 32'(bus.out_valid), 32'd0);

    // Reset pulsed during CALC aborts the update
    bus.joy_in   = {12'd4095, 12'd4095};
    bus.in_valid = 1'b1;
    tick();                                  // accepted, cycle 1 CALC
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    tick();
    check("abort_sp", 32'(bus.setpoint), 32'd0);
    check("abort_ov", 32'(bus.out_valid), 32'd0);
    reset_n = 1'b1;
    tick();
    check("abort_ov2", 32'(bus.out_valid), 32'd0);
    tick();
    check("abort_ov3", 32'(bus.out_valid), 32'd0);
    check("abort_sp2", 32'(bus.setpoint), 32'd0);
    run_set("after_abort", 12'd4095, 12'd0, 13'h0054, 13'h1FAB);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
